fifo_i_drain: RTL

Requester-side client of the SRAM FIFO controller's master port. It drains length-prefixed packets from the inbound FIFO (fifo_i) using the master_read / master_hint handshake. Each 16-bit word is serialized high byte first onto a valid/ready byte stream toward the Si4463 TX-FIFO loader on the SPI master side. It sits between the SRAM controller and the radio TX path, and is the read-side counterpart of the controller's request/arbitration logic.

---
 rtl/fifo_i_drain.sv | 100 ++++++++++
 1 files changed

// File: rtl/fifo_i_drain.sv
// fifo_i_drain: drains length-prefixed packets from fifo_i and serializes them high byte first onto a valid/ready byte stream
module fifo_i_drain #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_LEN = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fifo_i_empty,
  input  logic        master_hint,
  input  logic [15:0] master_data_from_sram,
  output logic        master_read,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic        busy,
  output logic        err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, REQ_LEN, WAIT_LEN, REQ_DATA, WAIT_DATA, HI, LO} state_t;
  state_t state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [10:0] rem, rem_n, len;
  logic [15:0] word, word_n;
  logic first, first_n, mr_n, err_n, accept, timeout;
  assign len = master_data_from_sram[10:0];
  assign tx_valid = state == HI || state == LO;
  assign accept = tx_valid && tx_ready;
  assign timeout = tmr == TW'(TIMEOUT_CYCLES - 1);
  assign tx_data = state == HI ? word[15:8] : state == LO ? word[7:0] : 8'h00;
  assign tx_sop = tx_valid && first;
  assign tx_eop = tx_valid && rem == 11'd1;
  assign busy = state != IDLE;
  // state and datapath registers; reset clears everything including an outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr <= '0;
      rem <= '0;
      word <= '0;
      first <= 1'b0;
      master_read <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      tmr <= tmr_n;
      rem <= rem_n;
      word <= word_n;
      first <= first_n;
      master_read <= mr_n;
      err <= err_n;
    end
  end
  // next-state: request/wait handshake per word, then stream its bytes; master_read drops on the hint edge
  always_comb begin
    state_n = state;
    tmr_n = tmr;
    rem_n = rem;
    word_n = word;
    first_n = first;
    mr_n = master_read;
    err_n = 1'b0;
    case (state)
      IDLE: if (enable && !fifo_i_empty) state_n = REQ_LEN;
      REQ_LEN, REQ_DATA: if (!fifo_i_empty) begin
        mr_n = 1'b1;
        tmr_n = '0;
        state_n = state == REQ_LEN ? WAIT_LEN : WAIT_DATA;
      end
      WAIT_LEN, WAIT_DATA: begin
        if (master_hint) begin
          mr_n = 1'b0;
          if (state == WAIT_DATA) begin
            word_n = master_data_from_sram;
            state_n = HI;
          end else if (len == 11'd0 || len > 11'(MAX_LEN)) begin
            err_n = 1'b1;
            state_n = IDLE;
          end else begin
            rem_n = len;
            first_n = 1'b1;
            state_n = REQ_DATA;
          end
        end else if (timeout) begin
          mr_n = 1'b0;
          err_n = 1'b1;
          state_n = IDLE;
        end else tmr_n = tmr + TW'(1);
      end
      HI, LO: if (accept) begin
        rem_n = rem - 11'd1;
        first_n = 1'b0;
        state_n = rem == 11'd1 ? IDLE : state == HI ? LO : REQ_DATA;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
